mmio_memory: RTL and testbench
==============================

MMIO_MEMORY -- requirements
Module: mmio_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width; legal range 8..32.
REQ-003 SHALL have parameter MEM_DEPTH, default 65536, array words; must be <= 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra access cycles; legal range 0..7.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, console FIFO entries; power of 2, >= 2.
REQ-006 SHALL have parameters UART_ADDR (default 16'hF010), HALT_ADDR (default 16'hF020) and HALT_CODE (default 8'hC0).
REQ-007 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-009 SHALL have port req, input, 1, access request; held with its qualifiers until ready.
REQ-010 SHALL have port write_en, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port address, input, ADDR_W, access address.
REQ-012 SHALL have port data_in, input, DATA_W, write data.
REQ-013 SHALL have port data_out, output, DATA_W, registered read data; valid while ready=1.
REQ-014 SHALL have port ready, output, 1, one-cycle access-complete pulse.
REQ-015 SHALL have port tx_valid, output, 1, console FIFO not empty.
REQ-016 SHALL have port tx_data, output, 8, console FIFO head character.
REQ-017 SHALL have port tx_ready, input, 1, consumer pop; pops on valid&&ready.
REQ-018 SHALL have port halt, output, 1, sticky simulation-end flag.

Function
REQ-019 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; IDLE->WAIT on req=1; WAIT counts WAIT_STATES cycles (0 = one cycle); DONE asserts ready for exactly one cycle.
REQ-020 SHALL give access latency of WAIT_STATES+2 cycles from req sampled high to ready high.
REQ-021 SHALL commit writes, FIFO pushes and halt set on the clock edge that leaves DONE; no side effect earlier.
REQ-022 SHALL ignore req while not in IDLE; req held high after ready starts a new access on the following cycle.
REQ-023 SHALL serve array reads/writes for address < MEM_DEPTH, excluding UART_ADDR and HALT_ADDR.
REQ-024 SHALL return 0 on reads and drop writes for unmapped addresses >= MEM_DEPTH.
REQ-025 SHALL push {1'b0, data_in[6:0]} into the console FIFO on a write to UART_ADDR; the array is not written.
REQ-026 SHALL stall in WAIT (ready withheld) on a UART_ADDR write while the FIFO is full, until an entry frees.
REQ-027 SHALL return {full_n, empty} in bits [1:0], zero-extended, on a read of UART_ADDR, where full_n = not full.
REQ-028 SHALL set halt on a write of HALT_CODE (low 8 bits) to HALT_ADDR; other values are ignored; halt stays 1 until reset.
REQ-029 SHALL return {halt}, zero-extended, on a read of HALT_ADDR.
REQ-030 SHALL keep the FIFO count unchanged on simultaneous push and pop; pop on empty is ignored.
REQ-031 SHALL keep data_out 0 whenever ready=0.

Reset
REQ-032 SHALL on reset: state IDLE, ready 0, data_out 0, FIFO empty (tx_valid 0, tx_data 0), halt 0, wait counter 0.
REQ-033 SHALL abort an in-flight access on reset mid-operation, with no write, push or halt committed.
REQ-034 SHALL NOT clear array contents on reset; a testbench loads them hierarchically.

Structure
REQ-035 SHALL take the FSM state encoding and the default UART_ADDR, HALT_ADDR and HALT_CODE constants from shared package m6502_pkg.
REQ-036 SHALL implement the console FIFO as sub-module console_fifo, with parameters DEPTH and WIDTH=8 and ports push/pop/full/empty.

Verification
REQ-037 SHALL cover: WAIT_STATES=0, write 8'h5A to 16'h0010, then read 16'h0010 -> each ready 2 cycles after req, data_out=8'h5A.
REQ-038 SHALL cover: WAIT_STATES=3, read 16'h0000 holding 8'hA9 -> ready exactly 5 cycles after req, data_out=8'hA9.
REQ-039 SHALL cover: tx_ready=0, five writes of 8'hC8 to 16'hF010 -> four complete; fifth stalls; tx_data=8'h48; after one pop fifth completes.
REQ-040 SHALL cover: write 8'h00 to 16'hF020 -> halt=0; write 8'hC0 -> halt=1 on ready cycle; read 16'hF020 -> 1.
REQ-041 SHALL cover: reset asserted in WAIT of a write 8'h77 to 16'h0020 -> ready never pulses, address 16'h0020 keeps old value.
REQ-042 SHALL cover: FIFO holding 2 entries, push and pop in the same cycle -> count stays 2, order preserved.

Source files
------------

// File: rtl/m6502_pkg.sv
// Shared definitions for the 6502 system memory map: access FSM encoding
// and the default console/halt register addresses.
package m6502_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [15:0] UART_ADDR_DEFAULT = 16'hF010;
  localparam logic [15:0] HALT_ADDR_DEFAULT = 16'hF020;
  localparam logic [7:0]  HALT_CODE_DEFAULT = 8'hC0;

  // Console characters are 7-bit ASCII; bit 7 is always cleared.
  function automatic logic [7:0] console_char(input logic [6:0] c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Small power-of-two FIFO buffering console characters until the consumer pops them.
module console_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : buf_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) buf_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_memory.sv
// Wait-stated memory with memory-mapped console output and a sticky halt register.
// Every access runs IDLE -> WAIT -> DONE; all side effects commit on the edge leaving DONE.
module mmio_memory
  import m6502_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                MEM_DEPTH   = 65536,
  parameter int                WAIT_STATES = 0,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] UART_ADDR   = ADDR_W'(UART_ADDR_DEFAULT),
  parameter logic [ADDR_W-1:0] HALT_ADDR   = ADDR_W'(HALT_ADDR_DEFAULT),
  parameter logic [7:0]        HALT_CODE   = HALT_CODE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              halt
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  mem_state_e        state_q;
  logic [2:0]        wait_cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] data_out_q;
  logic              halt_q;

  logic              is_uart, is_halt, is_mem;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rdata_d;
  logic              commit, uart_stall;
  logic              fifo_push, fifo_full, fifo_empty;

  // Register addresses take priority over the array even if they fall inside it.
  assign is_uart = (address == UART_ADDR);
  assign is_halt = (address == HALT_ADDR);
  assign is_mem  = (33'(address) < 33'(MEM_DEPTH)) && !is_uart && !is_halt;
  assign mem_idx = address[IDX_W-1:0];

  assign commit     = (state_q == ST_DONE);
  assign uart_stall = write_en && is_uart && fifo_full;
  assign fifo_push  = commit && write_en && is_uart;

  always_comb begin
    rdata_d = '0;
    if (is_uart)      rdata_d = DATA_W'({~fifo_full, fifo_empty});
    else if (is_halt) rdata_d = DATA_W'(halt_q);
    else if (is_mem)  rdata_d = mem[mem_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      data_out_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q != WAIT_LAST) wait_cnt_q <= wait_cnt_q + 3'd1;
          else if (!uart_stall)        state_q    <= ST_DONE;
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          wait_cnt_q <= '0;
          ready_q    <= 1'b1;
          if (!write_en) data_out_q <= rdata_d;
          if (write_en && is_halt && (data_in[7:0] == HALT_CODE)) halt_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array contents survive reset so a bench can preload them.
  always_ff @(posedge clock) begin
    if (commit && write_en && is_mem) mem[mem_idx] <= data_in;
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (console_char(data_in[6:0])),
    .pop   (tx_ready),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = !fifo_empty;
  assign ready    = ready_q;
  assign data_out = data_out_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_mmio_memory.sv
// Directed bench for mmio_memory: one zero-wait instance with a reduced array
// and one three-wait-state instance, both checked through a scoreboard queue.
module tb_mmio_memory;

  typedef struct {
    logic [7:0] data;
    bit         chk;
    int         lat;
    int         start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic        req = 1'b0, we = 1'b0, sel = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic        tx_ready = 1'b0, tx_ready3 = 1'b0;

  logic        req0, req3;
  logic [7:0]  dout0, dout3, txd0, txd3;
  logic        ready0, ready3, txv0, txv3, halt0, halt3;
  logic        rdy;
  logic [7:0]  dout;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   saw;

  assign req0 = req && !sel;
  assign req3 = req && sel;
  assign rdy  = sel ? ready3 : ready0;
  assign dout = sel ? dout3 : dout0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_memory #(.MEM_DEPTH(32768)) dut0 (
    .clock(clk), .reset(rst0), .req(req0), .write_en(we), .address(addr),
    .data_in(din), .data_out(dout0), .ready(ready0), .tx_valid(txv0),
    .tx_data(txd0), .tx_ready(tx_ready), .halt(halt0)
  );

  mmio_memory #(.WAIT_STATES(3)) dut3 (
    .clock(clk), .reset(rst3), .req(req3), .write_en(we), .address(addr),
    .data_in(din), .data_out(dout3), .ready(ready3), .tx_valid(txv3),
    .tx_data(txd3), .tx_ready(tx_ready3), .halt(halt3)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit w, input logic [15:0] a, input logic [7:0] d,
                       input bit chk, input logic [7:0] exp_d, input int lat);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; din = d;
    e.data = exp_d; e.chk = chk; e.lat = lat; e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic finish(input string tag);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy && n < 64);
    req = 1'b0;
    e = sb.pop_front();
    check(32'(rdy), 'h1, {tag, "_ready"});
    if (rdy) begin
      if (e.lat >= 0) check(cyc - e.start - 1, e.lat, {tag, "_latency"});
      if (e.chk) check(32'(dout), 32'(e.data), {tag, "_data"});
    end
  endtask

  task automatic acc(input bit w, input logic [15:0] a, input logic [7:0] d,
                     input bit chk, input logic [7:0] exp_d, input int lat, input string tag);
    start(w, a, d, chk, exp_d, lat);
    finish(tag);
  endtask

  task automatic pop_one();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    dut3.mem[0] = 8'hA9;
    repeat (3) @(negedge clk);
    check(32'(ready0), 'h0, "rst_ready");
    check(32'(dout0), 'h0, "rst_data_out");
    check(32'(txv0), 'h0, "rst_tx_valid");
    check(32'(txd0), 'h0, "rst_tx_data");
    check(32'(halt0), 'h0, "rst_halt");
    check(32'({ready3, txv3, txd3, halt3}), 'h0, "rst_dut3_outputs");
    rst0 = 1'b0; rst3 = 1'b0;

    // Basic array write/read, zero wait states.
    acc(1'b1, 16'h0010, 8'h5A, 1'b0, 8'h00, 2, "wr_0010");
    acc(1'b0, 16'h0010, 8'h00, 1'b1, 8'h5A, 2, "rd_0010");
    @(negedge clk);
    check(32'(dout0), 'h0, "data_out_idle_zero");

    // Unmapped region above the reduced array.
    acc(1'b1, 16'h9000, 8'h33, 1'b0, 8'h00, 2, "wr_unmapped");
    acc(1'b0, 16'h9000, 8'h00, 1'b1, 8'h00, 2, "rd_unmapped");

    // Three wait states on the second instance.
    sel = 1'b1;
    acc(1'b0, 16'h0000, 8'h00, 1'b1, 8'hA9, 5, "rd_ws3");
    sel = 1'b0;

    // Console: status when empty, fill to full, stall on the fifth write.
    acc(1'b0, 16'hF010, 8'h00, 1'b1, 8'h03, 2, "uart_stat_empty");
    for (int i = 0; i < 4; i++) acc(1'b1, 16'hF010, 8'hC8, 1'b0, 8'h00, 2, "uart_fill");
    check(32'(txd0), 'h48, "uart_head");
    acc(1'b0, 16'hF010, 8'h00, 1'b1, 8'h00, 2, "uart_stat_full");
    start(1'b1, 16'hF010, 8'hC8, 1'b0, 8'h00, -1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw |= ready0;
    end
    check(32'(saw), 'h0, "uart_stall_no_ready");
    pop_one();
    finish("uart_fifth");
    check(32'(txv0), 'h1, "uart_refilled_valid");

    // Drain, then pop on empty must be harmless.
    for (int i = 0; i < 4; i++) begin
      check(32'(txd0), 'h48, "uart_drain_data");
      pop_one();
    end
    check(32'(txv0), 'h0, "uart_drained");
    pop_one();
    check(32'({txv0, txd0}), 'h0, "uart_pop_empty");

    // Two entries, then push and pop on the same edge.
    acc(1'b1, 16'hF010, 8'h41, 1'b0, 8'h00, 2, "uart_a");
    acc(1'b1, 16'hF010, 8'h42, 1'b0, 8'h00, 2, "uart_b");
    start(1'b1, 16'hF010, 8'hC3, 1'b0, 8'h00, 2);
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b1;
    finish("uart_pushpop");
    tx_ready = 1'b0;
    check(32'(txd0), 'h42, "pushpop_head");
    acc(1'b0, 16'hF010, 8'h00, 1'b1, 8'h02, 2, "pushpop_status");
    pop_one();
    check(32'(txd0), 'h43, "pushpop_second");
    pop_one();
    check(32'(txv0), 'h0, "pushpop_empty");

    // Halt register.
    acc(1'b1, 16'hF020, 8'h00, 1'b0, 8'h00, 2, "halt_wr_00");
    check(32'(halt0), 'h0, "halt_ignore_00");
    acc(1'b1, 16'hF020, 8'hC0, 1'b0, 8'h00, 2, "halt_wr_c0");
    check(32'(halt0), 'h1, "halt_set");
    acc(1'b0, 16'hF020, 8'h00, 1'b1, 8'h01, 2, "halt_rd");

    // Reset in the middle of a wait-stated write.
    sel = 1'b1;
    acc(1'b1, 16'h0020, 8'h11, 1'b0, 8'h00, 5, "ws3_wr_0020");
    saw = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0020; din = 8'h77;
    repeat (2) begin
      @(negedge clk);
      saw |= ready3;
    end
    rst3 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      saw |= ready3;
    end
    req = 1'b0; rst3 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw |= ready3;
    end
    check(32'(saw), 'h0, "rstwait_no_ready");
    acc(1'b0, 16'h0020, 8'h00, 1'b1, 8'h11, 5, "rstwait_keep");
    sel = 1'b0;

    check(sb.size(), 'h0, "scoreboard_empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
